// File: rtl/stopwatch_timer_pkg.sv
// Shared types, digit limits and BCD helpers for the stopwatch/countdown timer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_EXPIRED = 2'd2
  } sw_state_e;

  localparam int TENTHS_MAX   = 9;
  localparam int SEC_ONES_MAX = 9;
  localparam int SEC_TENS_MAX = 5;
  localparam int BCD_MAX      = 9;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] digit, input logic [3:0] max_val);
    return (digit > max_val) ? max_val : digit;
  endfunction

  function automatic logic [11:0] int_to_bcd3(input int unsigned val);
    logic [11:0] r;
    r[3:0]  = 4'(val % 10);
    r[7:4]  = 4'((val / 10) % 10);
    r[11:8] = 4'((val / 100) % 10);
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_timer_bcd_digit_counter.sv
// Single BCD digit: clear > load > count, wraps at MAX going up and at 0 going down.
module bcd_digit_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 9
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             enable_i,
  input  logic             dir_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] value_o,
  output logic             carry_out_o,
  output logic             borrow_out_o
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clear_i) begin
      value_d = '0;
    end else if (load_i) begin
      value_d = load_val_i;
    end else if (enable_i) begin
      if (!dir_i) value_d = (value_q == MAX_V) ? '0 : value_q + WIDTH'(1);
      else        value_d = (value_q == '0) ? MAX_V : value_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) value_q <= '0;
    else           value_q <= value_d;
  end

  assign value_o      = value_q;
  assign carry_out_o  = (value_q == MAX_V);
  assign borrow_out_o = (value_q == '0);

endmodule

// File: rtl/stopwatch_timer.sv
// BCD stopwatch / countdown timer driven by a 10 Hz tick, with preset load and lap hold.
// reset_ni is the asynchronous active-low reset.
//
//   state      | meaning
//   STOPPED    | count held, accepts start/load
//   RUNNING    | counting on tick in the latched direction
//   EXPIRED    | countdown reached 00:00.0; waits for clear or load
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int MIN_DIGITS = 1,
  parameter int MAX_MIN    = 9
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    tick_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    clear_i,
  input  logic                    mode_i,
  input  logic                    load_i,
  input  logic [4*MIN_DIGITS-1:0] preset_min_i,
  input  logic [6:0]              preset_sec_i,
  input  logic                    lap_i,
  output logic [4*MIN_DIGITS-1:0] minutes_o,
  output logic [2:0]              sec_tens_o,
  output logic [3:0]              sec_ones_o,
  output logic [3:0]              tenths_o,
  output logic                    running_o,
  output logic                    done_o,
  output logic                    wrapped_o,
  output logic                    lap_active_o
);

  localparam int MW = 4 * MIN_DIGITS;
  localparam logic [11:0]   MAX_MIN_BCD12 = int_to_bcd3(MAX_MIN);
  localparam logic [MW-1:0] MAX_MIN_BCD   = MAX_MIN_BCD12[MW-1:0];

  sw_state_e state_q, state_d;
  logic      mode_q, wrapped_q, lap_active_q;
  logic [MW-1:0] snap_min_q;
  logic [2:0]    snap_st_q;
  logic [3:0]    snap_so_q, snap_t_q;

  logic [3:0]    t_live, so_live;
  logic [2:0]    st_live;
  logic [MW-1:0] min_live;
  logic t_carry, t_borrow, so_carry, so_borrow, st_carry, st_borrow;
  logic [MIN_DIGITS-1:0] min_carry, min_borrow, en_min;

  logic up, count_en, load_acc, en_so, en_st, wrap_up;
  logic count_zero, at_one_tenth, expire_hit;
  logic [3:0]    ld_so;
  logic [2:0]    ld_st;
  logic [MW-1:0] ld_min_dig, ld_min;

  assign up       = !mode_q;
  assign count_en = tick_i && (state_q == ST_RUNNING) && !clear_i;
  assign load_acc = load_i && (state_q != ST_RUNNING) && !clear_i;

  // Ripple enable: a digit steps when every lower digit is at its terminal value.
  assign en_so = count_en && (up ? t_carry : t_borrow);
  assign en_st = en_so && (up ? so_carry : so_borrow);

  always_comb begin
    en_min    = '0;
    en_min[0] = en_st && (up ? st_carry : st_borrow);
    for (int i = 1; i < MIN_DIGITS; i++) begin
      en_min[i] = en_min[i-1] && (up ? min_carry[i-1] : min_borrow[i-1]);
    end
  end

  assign wrap_up      = en_min[0] && up && (min_live == MAX_MIN_BCD);
  assign count_zero   = (t_live == 4'd0) && (so_live == 4'd0) && (st_live == 3'd0) && (min_live == '0);
  assign at_one_tenth = (t_live == 4'd1) && (so_live == 4'd0) && (st_live == 3'd0) && (min_live == '0);
  assign expire_hit   = count_en && mode_q && at_one_tenth;

  always_comb begin
    ld_so      = bcd_clamp(preset_sec_i[3:0], 4'(SEC_ONES_MAX));
    ld_st      = 3'(bcd_clamp({1'b0, preset_sec_i[6:4]}, 4'(SEC_TENS_MAX)));
    ld_min_dig = '0;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      ld_min_dig[4*i +: 4] = bcd_clamp(preset_min_i[4*i +: 4], 4'(BCD_MAX));
    end
    // Packed BCD with valid digits orders the same as binary, so a plain compare works.
    ld_min = (ld_min_dig > MAX_MIN_BCD) ? MAX_MIN_BCD : ld_min_dig;
  end

  bcd_digit_counter #(.WIDTH(4), .MAX(TENTHS_MAX)) u_tenths (
    .clk_i(clk_i), .reset_ni(reset_ni), .enable_i(count_en), .dir_i(mode_q),
    .load_i(load_acc), .load_val_i(4'd0), .clear_i(clear_i),
    .value_o(t_live), .carry_out_o(t_carry), .borrow_out_o(t_borrow)
  );

  bcd_digit_counter #(.WIDTH(4), .MAX(SEC_ONES_MAX)) u_sec_ones (
    .clk_i(clk_i), .reset_ni(reset_ni), .enable_i(en_so), .dir_i(mode_q),
    .load_i(load_acc), .load_val_i(ld_so), .clear_i(clear_i),
    .value_o(so_live), .carry_out_o(so_carry), .borrow_out_o(so_borrow)
  );

  bcd_digit_counter #(.WIDTH(3), .MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk_i(clk_i), .reset_ni(reset_ni), .enable_i(en_st), .dir_i(mode_q),
    .load_i(load_acc), .load_val_i(ld_st), .clear_i(clear_i),
    .value_o(st_live), .carry_out_o(st_carry), .borrow_out_o(st_borrow)
  );

  for (genvar g = 0; g < MIN_DIGITS; g++) begin : g_min
    bcd_digit_counter #(.WIDTH(4), .MAX(BCD_MAX)) u_min (
      .clk_i(clk_i), .reset_ni(reset_ni), .enable_i(en_min[g]), .dir_i(mode_q),
      .load_i(load_acc), .load_val_i(ld_min[4*g +: 4]), .clear_i(clear_i || wrap_up),
      .value_o(min_live[4*g +: 4]), .carry_out_o(min_carry[g]), .borrow_out_o(min_borrow[g])
    );
  end

  // The top minute digit never feeds a higher digit.
  logic unused_top_term;
  assign unused_top_term = min_carry[MIN_DIGITS-1] ^ min_borrow[MIN_DIGITS-1];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= ST_STOPPED;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_STOPPED;
    end else begin
      case (state_q)
        ST_STOPPED: if (start_i && !stop_i && !(mode_i && count_zero)) state_d = ST_RUNNING;
        ST_RUNNING: begin
          if (stop_i)          state_d = ST_STOPPED;
          else if (expire_hit) state_d = ST_EXPIRED;
        end
        ST_EXPIRED: if (load_i) state_d = ST_STOPPED;
        default:    state_d = ST_STOPPED;
      endcase
    end
  end

  always_comb begin
    running_o    = (state_q == ST_RUNNING);
    done_o       = (state_q == ST_EXPIRED);
    wrapped_o    = wrapped_q;
    lap_active_o = lap_active_q;
    minutes_o    = lap_active_q ? snap_min_q : min_live;
    sec_tens_o   = lap_active_q ? snap_st_q  : st_live;
    sec_ones_o   = lap_active_q ? snap_so_q  : so_live;
    tenths_o     = lap_active_q ? snap_t_q   : t_live;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      mode_q       <= 1'b0;
      wrapped_q    <= 1'b0;
      lap_active_q <= 1'b0;
      snap_min_q   <= '0;
      snap_st_q    <= '0;
      snap_so_q    <= '0;
      snap_t_q     <= '0;
    end else begin
      wrapped_q <= wrap_up;
      if (state_q == ST_STOPPED && state_d == ST_RUNNING) mode_q <= mode_i;
      if (clear_i) begin
        lap_active_q <= 1'b0;
      end else if (lap_i) begin
        if (lap_active_q) begin
          lap_active_q <= 1'b0;
        end else if (state_q == ST_RUNNING) begin
          lap_active_q <= 1'b1;
          snap_min_q   <= min_live;
          snap_st_q    <= st_live;
          snap_so_q    <= so_live;
          snap_t_q     <= t_live;
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed bench for stopwatch_timer: vector table plus wrap, lap and async-reset sequences.
module tb_stopwatch_timer;

  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  logic tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, mode = 1'b0, load = 1'b0, lap = 1'b0;
  logic [3:0] pmin1 = 4'd0;
  logic [7:0] pmin2 = 8'd0;
  logic [6:0] psec = 7'd0;

  logic [3:0] min1, so1, t1;
  logic [2:0] st1;
  logic       run1, done1, wrap1, la1;
  logic [7:0] min2;
  logic [3:0] so2, t2;
  logic [2:0] st2;
  logic       run2, done2, wrap2, la2;

  int checks = 0;
  int passes = 0;

  always #5 clk_i = ~clk_i;

  stopwatch_timer #(.MIN_DIGITS(1), .MAX_MIN(9)) dut1 (
    .clk_i(clk_i), .reset_ni(reset_ni), .tick_i(tick), .start_i(start), .stop_i(stop),
    .clear_i(clear), .mode_i(mode), .load_i(load), .preset_min_i(pmin1), .preset_sec_i(psec),
    .lap_i(lap), .minutes_o(min1), .sec_tens_o(st1), .sec_ones_o(so1), .tenths_o(t1),
    .running_o(run1), .done_o(done1), .wrapped_o(wrap1), .lap_active_o(la1)
  );

  stopwatch_timer #(.MIN_DIGITS(2), .MAX_MIN(59)) dut2 (
    .clk_i(clk_i), .reset_ni(reset_ni), .tick_i(tick), .start_i(start), .stop_i(stop),
    .clear_i(clear), .mode_i(mode), .load_i(load), .preset_min_i(pmin2), .preset_sec_i(psec),
    .lap_i(lap), .minutes_o(min2), .sec_tens_o(st2), .sec_ones_o(so2), .tenths_o(t2),
    .running_o(run2), .done_o(done2), .wrapped_o(wrap2), .lap_active_o(la2)
  );

  typedef struct {
    logic start, stop, clear, mode, load, tick, lap;
    logic [3:0] pmin;
    logic [6:0] psec;
    logic [31:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] pk1(input logic [3:0] m, input logic [2:0] s10, input logic [3:0] s1,
                                      input logic [3:0] t, input logic r, input logic d, input logic w,
                                      input logic la);
    return {13'd0, m, s10, s1, t, r, d, w, la};
  endfunction

  function automatic logic [31:0] pk2(input logic [7:0] m, input logic [2:0] s10, input logic [3:0] s1,
                                      input logic [3:0] t, input logic r, input logic d, input logic w,
                                      input logic la);
    return {9'd0, m, s10, s1, t, r, d, w, la};
  endfunction

  function automatic logic [31:0] act1();
    return pk1(min1, st1, so1, t1, run1, done1, wrap1, la1);
  endfunction

  function automatic logic [31:0] act2();
    return pk2(min2, st2, so2, t2, run2, done2, wrap2, la2);
  endfunction

  function automatic vec_t mkv(input logic st_, input logic sp, input logic cl, input logic md,
                               input logic ld, input logic tk, input logic lp,
                               input logic [3:0] pm, input logic [6:0] ps, input logic [31:0] e);
    vec_t v;
    v.start = st_; v.stop = sp; v.clear = cl; v.mode = md; v.load = ld; v.tick = tk; v.lap = lp;
    v.pmin = pm; v.psec = ps; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic step(input logic st_, input logic sp, input logic cl, input logic md, input logic ld,
                      input logic tk, input logic lp, input logic [3:0] pm, input logic [6:0] ps);
    start = st_; stop = sp; clear = cl; mode = md; load = ld; tick = tk; lap = lp;
    pmin1 = pm; psec = ps;
    @(posedge clk_i);
    #1;
    start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0; tick = 1'b0; lap = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, mode, 1'b0, 1'b1, 1'b0, pmin1, psec);
  endtask

  initial begin
    // start stop clear mode load tick lap pmin psec | min s10 s1 t run done wrap lap_active
    vq.push_back(mkv(0,0,0,0,1,0,0, 4'hC, 7'h7B, pk1(9,5,9,0, 0,0,0,0)));
    vq.push_back(mkv(1,1,0,0,0,0,0, 4'h0, 7'h00, pk1(9,5,9,0, 0,0,0,0)));
    vq.push_back(mkv(0,0,1,0,1,1,0, 4'h3, 7'h12, pk1(0,0,0,0, 0,0,0,0)));
    vq.push_back(mkv(1,0,0,1,0,0,0, 4'h0, 7'h00, pk1(0,0,0,0, 0,0,0,0)));
    vq.push_back(mkv(0,0,0,1,1,0,0, 4'h0, 7'h01, pk1(0,0,1,0, 0,0,0,0)));
    vq.push_back(mkv(1,0,0,1,0,0,0, 4'h0, 7'h00, pk1(0,0,1,0, 1,0,0,0)));
    vq.push_back(mkv(0,0,0,1,0,1,0, 4'h0, 7'h00, pk1(0,0,0,9, 1,0,0,0)));
    vq.push_back(mkv(0,0,0,0,0,1,0, 4'h0, 7'h00, pk1(0,0,0,8, 1,0,0,0)));
    vq.push_back(mkv(0,0,0,0,1,1,0, 4'h5, 7'h00, pk1(0,0,0,7, 1,0,0,0)));
    for (int k = 6; k >= 1; k--)
      vq.push_back(mkv(0,0,0,0,0,1,0, 4'h0, 7'h00, pk1(0,0,0,4'(k), 1,0,0,0)));
    vq.push_back(mkv(0,0,0,0,0,1,0, 4'h0, 7'h00, pk1(0,0,0,0, 0,1,0,0)));
    vq.push_back(mkv(1,0,0,0,0,1,0, 4'h0, 7'h00, pk1(0,0,0,0, 0,1,0,0)));
    vq.push_back(mkv(0,0,1,0,0,0,0, 4'h0, 7'h00, pk1(0,0,0,0, 0,0,0,0)));
    vq.push_back(mkv(0,0,0,0,1,0,0, 4'h1, 7'h00, pk1(1,0,0,0, 0,0,0,0)));
    vq.push_back(mkv(1,0,0,1,0,0,0, 4'h0, 7'h00, pk1(1,0,0,0, 1,0,0,0)));
    vq.push_back(mkv(0,0,0,1,0,1,0, 4'h0, 7'h00, pk1(0,5,9,9, 1,0,0,0)));
    vq.push_back(mkv(0,1,0,1,0,0,0, 4'h0, 7'h00, pk1(0,5,9,9, 0,0,0,0)));
    vq.push_back(mkv(0,0,0,1,0,1,0, 4'h0, 7'h00, pk1(0,5,9,9, 0,0,0,0)));
    vq.push_back(mkv(0,0,0,1,0,0,1, 4'h0, 7'h00, pk1(0,5,9,9, 0,0,0,0)));
    vq.push_back(mkv(1,0,0,0,0,1,0, 4'h0, 7'h00, pk1(0,5,9,9, 1,0,0,0)));
    vq.push_back(mkv(0,0,0,0,0,1,0, 4'h0, 7'h00, pk1(1,0,0,0, 1,0,0,0)));
    vq.push_back(mkv(0,0,1,0,0,0,0, 4'h0, 7'h00, pk1(0,0,0,0, 0,0,0,0)));

    repeat (2) @(posedge clk_i);
    #1;
    check("reset_d1", act1(), pk1(0,0,0,0, 0,0,0,0));
    check("reset_d2", act2(), pk2(0,0,0,0, 0,0,0,0));
    reset_ni = 1'b1;
    @(posedge clk_i);
    #1;

    foreach (vq[i]) begin
      step(vq[i].start, vq[i].stop, vq[i].clear, vq[i].mode, vq[i].load, vq[i].tick, vq[i].lap,
           vq[i].pmin, vq[i].psec);
      check($sformatf("vec%0d", i), act1(), vq[i].exp);
    end

    // Up-count wrap on both minute widths.
    pmin2 = 8'h59;
    step(0,0,0,0,1,0,0, 4'h9, 7'h59);
    check("wrap_load_d2", act2(), pk2(8'h59,5,9,0, 0,0,0,0));
    step(1,0,0,0,0,0,0, 4'h9, 7'h59);
    tick_n(9);
    check("wrap_pre_d1", act1(), pk1(9,5,9,9, 1,0,0,0));
    check("wrap_pre_d2", act2(), pk2(8'h59,5,9,9, 1,0,0,0));
    tick_n(1);
    check("wrap_d1", act1(), pk1(0,0,0,0, 1,0,1,0));
    check("wrap_d2", act2(), pk2(8'h00,0,0,0, 1,0,1,0));
    step(0,0,0,0,0,0,0, 4'h0, 7'h00);
    check("wrap_pulse_end_d1", act1(), pk1(0,0,0,0, 1,0,0,0));
    check("wrap_pulse_end_d2", act2(), pk2(8'h00,0,0,0, 1,0,0,0));
    step(0,1,0,0,0,0,0, 4'h0, 7'h00);

    // Lap hold: frozen display while the live count advances.
    step(0,0,1,0,0,0,0, 4'h0, 7'h00);
    step(1,0,0,0,0,0,0, 4'h0, 7'h00);
    tick_n(12);
    check("lap_pre", act1(), pk1(0,0,1,2, 1,0,0,0));
    step(0,0,0,0,0,0,1, 4'h0, 7'h00);
    check("lap_capture", act1(), pk1(0,0,1,2, 1,0,0,1));
    tick_n(30);
    check("lap_frozen", act1(), pk1(0,0,1,2, 1,0,0,1));
    step(0,1,0,0,0,0,0, 4'h0, 7'h00);
    check("lap_stop_holds", act1(), pk1(0,0,1,2, 0,0,0,1));
    step(0,0,0,0,0,0,1, 4'h0, 7'h00);
    check("lap_release", act1(), pk1(0,4,2,0, 0,0,0,0) ^ pk1(0,4,2,0, 0,0,0,0) ^ pk1(0,0,4,2, 0,0,0,0));

    // Asynchronous reset in the middle of a run.
    step(0,0,1,0,0,0,0, 4'h0, 7'h00);
    step(0,0,0,0,1,0,0, 4'h3, 7'h27);
    step(1,0,0,0,0,0,0, 4'h3, 7'h27);
    tick_n(4);
    check("run_3274", act1(), pk1(3,2,7,4, 1,0,0,0));
    reset_ni = 1'b0;
    #2;
    check("async_reset_d1", act1(), pk1(0,0,0,0, 0,0,0,0));
    check("async_reset_d2", act2(), pk2(0,0,0,0, 0,0,0,0));
    #10;
    reset_ni = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
